// File: rtl/note_detector.sv
// Square-wave period meter and piano note decoder.
// Filters the decoded bin and drops to "no note" on silence.
module note_detector #(
  parameter longint unsigned CLK_HZ     = 100_000_000,
  parameter int              CW         = 20,
  parameter int              STABLE_CNT = 3,
  parameter int              TIMEOUT    = 524_287
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          FREQ_IN,
  output logic [3:0]    NOTE,
  output logic          NOTE_VALID,
  output logic          NOTE_STROBE,
  output logic [CW-1:0] PERIOD
);

  localparam longint unsigned CC = CLK_HZ * 100;

  localparam longint unsigned P_C4 = CC / 26163;
  localparam longint unsigned P_D  = CC / 29366;
  localparam longint unsigned P_E  = CC / 32963;
  localparam longint unsigned P_F  = CC / 34923;
  localparam longint unsigned P_G  = CC / 39200;
  localparam longint unsigned P_A  = CC / 44000;
  localparam longint unsigned P_B  = CC / 49388;
  localparam longint unsigned P_C5 = CC / 52325;

  localparam longint unsigned LO_L = P_C5 - (P_B - P_C5) / 2;
  localparam longint unsigned HI_L = P_C4 + (P_C4 - P_D) / 2;
  localparam longint unsigned M0_L = (P_C5 + P_B) / 2;
  localparam longint unsigned M1_L = (P_B + P_A) / 2;
  localparam longint unsigned M2_L = (P_A + P_G) / 2;
  localparam longint unsigned M3_L = (P_G + P_F) / 2;
  localparam longint unsigned M4_L = (P_F + P_E) / 2;
  localparam longint unsigned M5_L = (P_E + P_D) / 2;
  localparam longint unsigned M6_L = (P_D + P_C4) / 2;

  localparam logic [CW-1:0] LO = CW'(LO_L);
  localparam logic [CW-1:0] HI = CW'(HI_L);
  localparam logic [CW-1:0] M0 = CW'(M0_L);
  localparam logic [CW-1:0] M1 = CW'(M1_L);
  localparam logic [CW-1:0] M2 = CW'(M2_L);
  localparam logic [CW-1:0] M3 = CW'(M3_L);
  localparam logic [CW-1:0] M4 = CW'(M4_L);
  localparam logic [CW-1:0] M5 = CW'(M5_L);
  localparam logic [CW-1:0] M6 = CW'(M6_L);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);

  localparam int            RW = $clog2(STABLE_CNT + 1);
  localparam logic [RW-1:0] SC = RW'(STABLE_CNT);

  localparam logic [3:0] NONE = 4'b1111;

  logic [2:0]    sync_q;
  logic          rise;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [3:0]    bin;
  logic [3:0]    cand;
  logic [3:0]    cand_nx;
  logic [RW-1:0] run;
  logic [RW-1:0] run_nx;
  logic          meas;
  logic          tmo;

  assign rise       = sync_q[1] & ~sync_q[2];
  assign meas       = rise & armed;
  assign tmo        = armed & ~rise & (cnt == TO);
  assign NOTE_VALID = (NOTE != NONE);

  // Two-stage synchronizer plus a delay stage for edge detect.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], FREQ_IN};
  end

  // Map the running count (the period on an edge) to a note bin.
  always_comb begin
    bin = NONE;
    unique case (1'b1)
      (cnt >= LO && cnt <= M0): bin = 4'b0000;
      (cnt >  M0 && cnt <= M1): bin = 4'b0001;
      (cnt >  M1 && cnt <= M2): bin = 4'b0010;
      (cnt >  M2 && cnt <= M3): bin = 4'b0011;
      (cnt >  M3 && cnt <= M4): bin = 4'b0100;
      (cnt >  M4 && cnt <= M5): bin = 4'b0101;
      (cnt >  M5 && cnt <= M6): bin = 4'b0110;
      (cnt >  M6 && cnt <= HI): bin = 4'b0111;
      default:                  bin = NONE;
    endcase
  end

  // Candidate/run update for the measurement taken this cycle.
  always_comb begin
    cand_nx = bin;
    run_nx  = RW'(1);
    if (bin == cand) begin
      cand_nx = cand;
      run_nx  = (run == SC) ? SC : run + 1'b1;
    end
  end

  // Period counter: arm on first edge, measure on later edges.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      armed  <= 1'b0;
      cnt    <= '0;
      PERIOD <= '0;
    end else if (rise) begin
      armed <= 1'b1;
      cnt   <= CW'(1);
      if (armed) PERIOD <= cnt;
    end else if (tmo) begin
      armed <= 1'b0;
      cnt   <= '0;
    end else if (armed && cnt != TO) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stability filter and note register with change strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cand        <= NONE;
      run         <= '0;
      NOTE        <= NONE;
      NOTE_STROBE <= 1'b0;
    end else begin
      NOTE_STROBE <= 1'b0;
      if (meas) begin
        cand <= cand_nx;
        run  <= run_nx;
        if (run_nx == SC && cand_nx != NOTE) begin
          NOTE        <= cand_nx;
          NOTE_STROBE <= 1'b1;
        end
      end else if (tmo) begin
        cand <= NONE;
        run  <= '0;
        if (NOTE != NONE) begin
          NOTE        <= NONE;
          NOTE_STROBE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_detector.sv
// Directed bench for note_detector at CLK_HZ=1 MHz.
// Drives square waves of chosen periods and checks decoded notes.
module tb_note_detector;

  logic        CLK;
  logic        RESET_N;
  logic        FREQ_IN;
  logic [3:0]  NOTE;
  logic        NOTE_VALID;
  logic        NOTE_STROBE;
  logic [19:0] PERIOD;

  int n_tests = 0;
  int n_fail  = 0;
  int stb     = 0;
  int base    = 0;

  note_detector #(
    .CLK_HZ(1_000_000),
    .CW(20),
    .STABLE_CNT(3),
    .TIMEOUT(8000)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .FREQ_IN(FREQ_IN),
    .NOTE(NOTE),
    .NOTE_VALID(NOTE_VALID),
    .NOTE_STROBE(NOTE_STROBE),
    .PERIOD(PERIOD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (NOTE_STROBE) stb++;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int p);
    FREQ_IN = 1'b1;
    tick(p / 2);
    FREQ_IN = 1'b0;
    tick(p - p / 2);
  endtask

  initial begin
    RESET_N = 1'b1;
    FREQ_IN = 1'b0;
    #1 RESET_N = 1'b0;
    tick(3);
    chk("rst_note",   int'(NOTE), 15);
    chk("rst_valid",  int'(NOTE_VALID), 0);
    chk("rst_strobe", int'(NOTE_STROBE), 0);
    chk("rst_period", int'(PERIOD), 0);
    RESET_N = 1'b1;
    tick(2);

    base = stb;
    send(3822);
    send(3822);
    send(3822);
    chk("c4_wait", int'(NOTE), 15);
    send(3822);
    chk("c4_note",   int'(NOTE), 7);
    chk("c4_valid",  int'(NOTE_VALID), 1);
    chk("c4_period", int'(PERIOD), 3822);
    chk("c4_strobe", stb - base, 1);

    base = stb;
    send(2272);
    send(2272);
    send(2272);
    chk("a_hold", int'(NOTE), 7);
    send(2272);
    chk("a_note",   int'(NOTE), 2);
    chk("a_period", int'(PERIOD), 2272);
    chk("a_strobe", stb - base, 1);

    base = stb;
    for (int i = 0; i < 4; i++) send((i % 2 == 0) ? 3822 : 2272);
    chk("alt_note",   int'(NOTE), 2);
    chk("alt_strobe", stb - base, 0);

    base = stb;
    tick(8000 - 2272 - 20);
    chk("tmo_before", int'(NOTE), 2);
    tick(40);
    chk("tmo_note",   int'(NOTE), 15);
    chk("tmo_valid",  int'(NOTE_VALID), 0);
    chk("tmo_strobe", stb - base, 1);
    chk("tmo_period", int'(PERIOD), 3822);

    for (int i = 0; i < 4; i++) send(1855);
    chk("lo_in", int'(NOTE), 0);
    for (int i = 0; i < 3; i++) send(1854);
    chk("lo_out_wait", int'(NOTE), 0);
    send(4030);
    chk("lo_out", int'(NOTE), 15);
    send(4030);
    send(4030);
    chk("hi_in_wait", int'(NOTE), 15);
    send(4031);
    chk("hi_in", int'(NOTE), 7);
    send(4031);
    send(4031);
    chk("hi_out_wait", int'(NOTE), 7);
    send(1911);
    chk("hi_out", int'(NOTE), 15);
    send(1911);
    send(1911);

    FREQ_IN = 1'b1;
    tick(500);
    chk("pre_rst_note", int'(NOTE), 0);
    RESET_N = 1'b0;
    #2;
    chk("mid_rst_note",   int'(NOTE), 15);
    chk("mid_rst_valid",  int'(NOTE_VALID), 0);
    chk("mid_rst_strobe", int'(NOTE_STROBE), 0);
    chk("mid_rst_period", int'(PERIOD), 0);
    FREQ_IN = 1'b0;
    tick(4);
    RESET_N = 1'b1;
    tick(4);
    send(1911);
    chk("arm_period", int'(PERIOD), 0);
    chk("arm_note",   int'(NOTE), 15);
    FREQ_IN = 1'b1;
    tick(10);
    chk("first_meas", int'(PERIOD), 1911);
    FREQ_IN = 1'b0;
    tick(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
